branch_hazard_ctrl: RTL and testbench
=====================================

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 Parameter OPW, default 4: width of alu_op.
REQ-002 Parameter RADDR_W, default 4: register-address width.
REQ-003 Parameter BR_OP0 = 4'b1100, BR_OP1 = 4'b1101: branch opcodes.
REQ-004 Parameter FLUSH_DEPTH, default 2, legal 1..4: total flush cycles per taken branch.
REQ-005 Parameter LU_BUBBLES, default 1, legal 1..3: total stall cycles per load-use hazard.
REQ-006 Parameter CNT_W, default 16: statistics counter width.
REQ-007 Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX stage holds a real instruction.
- alu_op  in  OPW  EX opcode.
- e_flags  in  3  {Z,V,N} flags seen by the EX branch.
- e_ccc  in  3  EX branch condition code.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  RADDR_W  EX destination register.
- id_rs, id_rt  in  RADDR_W  ID source registers.
- id_rs_used, id_rt_used  in  1  ID source actually read.
- branch_taken  out  1  redirect PC this cycle.
- flush_if_id, flush_id_ex  out  1  squash the pipeline register.
- stall_pc_if_id  out  1  hold PC and IF/ID.
- busy  out  1  FSM not in IDLE.

Function
REQ-008 is_br SHALL be ex_valid & (alu_op==BR_OP0 | alu_op==BR_OP1).
REQ-009 cond SHALL be, by e_ccc:
- 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|!N; 101 Z|N; 110 V; 111 1.
REQ-010 take SHALL be is_br & cond; lu SHALL be ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
REQ-011 The FSM SHALL have three states: IDLE, FLUSH, STALL, plus a 2-bit down-counter cnt.
REQ-012 IDLE with take: branch_taken=1, flush_if_id=1, flush_id_ex=1 in the same cycle (combinational); if FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-2, else stay in IDLE.
REQ-013 IDLE with lu and no take: stall_pc_if_id=1, flush_id_ex=1 in the same cycle; if LU_BUBBLES>1, go to STALL with cnt=LU_BUBBLES-2, else stay in IDLE.
REQ-014 take and lu in the same cycle: take wins; lu is ignored.
REQ-015 FLUSH: flush_if_id=1, flush_id_ex=1, branch_taken=0; take and lu ignored; cnt==0 -> IDLE, else cnt decrements.
REQ-016 STALL: stall_pc_if_id=1, flush_id_ex=1; cnt==0 -> IDLE, else cnt decrements.
REQ-017 STALL with take: abort the stall; act as REQ-012 that cycle, with stall_pc_if_id=0.
REQ-018 busy SHALL be 1 exactly when the state is not IDLE.
REQ-019 Outputs not asserted by REQ-012..REQ-017 SHALL be 0.
REQ-020 branch_taken SHALL pulse exactly one cycle per taken branch.

Reset
REQ-021 When rst_n=0 at a clk rising edge: state=IDLE, cnt=0, statistics counters=0.
REQ-022 While rst_n=0, all outputs SHALL be 0, regardless of inputs.
REQ-023 Reset asserted mid-FLUSH or mid-STALL SHALL abandon the sequence; the first cycle after release is in IDLE.

Configuration
REQ-024 Macro BRANCH_HAZARD_STATS_EN, when defined, SHALL add:
- input stat_clr;
- outputs flush_cnt and stall_cnt, each CNT_W wide.
REQ-025 With the macro: flush_cnt +1 per branch_taken pulse; stall_cnt +1 per cycle with stall_pc_if_id=1.
- Both counters saturate at all-ones.
- stat_clr zeroes both synchronously and takes priority over increment.
REQ-026 Without the macro: those ports and counters are absent, and all other behaviour is identical.

Verification
REQ-027 Defaults; alu_op=1100, e_ccc=001, e_flags=100, ex_valid=1 -> branch_taken and both flushes asserted cycle 0; cycle 1 flushes=1, branch_taken=0; cycle 2 all 0, busy=0.
REQ-028 e_ccc=010, e_flags=001 (N set) -> no flush, no pulse; e_ccc=111, any flags -> taken.
REQ-029 LU_BUBBLES=3; ex_mem_read=1, ex_rd=5, id_rt=5, id_rt_used=1 -> stall_pc_if_id=1 for exactly 3 cycles; repeat with ex_rd=0 -> no stall.
REQ-030 Same cycle: take and lu both true -> branch_taken=1, stall_pc_if_id=0; taken branch in 2nd STALL cycle -> stall aborts, FLUSH_DEPTH flush cycles follow.
REQ-031 rst_n=0 during FLUSH cycle 1 -> all outputs 0 that cycle; IDLE after release.
REQ-032 With BRANCH_HAZARD_STATS_EN and CNT_W=2: 4 taken branches -> flush_cnt=3 (saturated); stat_clr asserted together with a taken branch -> flush_cnt=0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// branch_hazard_ctrl : taken-branch flush / load-use stall controller.
// Optional statistics counters: define BRANCH_HAZARD_STATS_EN.  Rev 1.0
// ============================================================================
module branch_hazard_ctrl #(
  parameter int               OPW         = 4,
  parameter int               RADDR_W     = 4,
  parameter logic [OPW-1:0]   BR_OP0      = OPW'(4'b1100),
  parameter logic [OPW-1:0]   BR_OP1      = OPW'(4'b1101),
  parameter int               FLUSH_DEPTH = 2,
  parameter int               LU_BUBBLES  = 1,
  parameter int               CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic [OPW-1:0]     alu_op,
  input  logic [2:0]         e_flags,
  input  logic [2:0]         e_ccc,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  output logic               branch_taken,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               stall_pc_if_id,
`ifdef BRANCH_HAZARD_STATS_EN
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
`endif
  output logic               busy
);

  localparam logic       c_FLUSH_MULTI = (FLUSH_DEPTH > 1);
  localparam logic       c_LU_MULTI    = (LU_BUBBLES > 1);
  localparam logic [1:0] c_FLUSH_INIT  = 2'(FLUSH_DEPTH - 2);
  localparam logic [1:0] c_LU_INIT     = 2'(LU_BUBBLES - 2);

  generate
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 4 || LU_BUBBLES < 1 || LU_BUBBLES > 3 || CNT_W < 1) begin : g_bad_param
      $error("branch_hazard_ctrl: parameter out of legal range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;

  logic w_z, w_v, w_n;
  logic w_cond, w_is_br, w_take, w_lu;
  logic w_bt, w_fif, w_fie, w_stall;

  assign w_z = e_flags[2];
  assign w_v = e_flags[1];
  assign w_n = e_flags[0];

  always_comb begin
    w_cond = 1'b0;
    case (e_ccc)
      3'b000:  w_cond = ~w_z;
      3'b001:  w_cond = w_z;
      3'b010:  w_cond = ~w_z & ~w_n;
      3'b011:  w_cond = w_n;
      3'b100:  w_cond = w_z | ~w_n;
      3'b101:  w_cond = w_z | w_n;
      3'b110:  w_cond = w_v;
      default: w_cond = 1'b1;
    endcase
  end

  assign w_is_br = ex_valid & ((alu_op == BR_OP0) | (alu_op == BR_OP1));
  assign w_take  = w_is_br & w_cond;
  assign w_lu    = ex_valid & ex_mem_read & (ex_rd != '0) &
                   ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bt        = 1'b0;
    w_fif       = 1'b0;
    w_fie       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_FLUSH: begin
        w_fif = 1'b1;
        w_fie = 1'b1;
        if (r_cnt == 2'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 2'd1;
      end
      S_IDLE, S_STALL: begin
        // A taken branch pre-empts both a fresh load-use hazard and a running stall.
        if (w_take) begin
          w_bt  = 1'b1;
          w_fif = 1'b1;
          w_fie = 1'b1;
          if (c_FLUSH_MULTI) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = c_FLUSH_INIT;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
          end
        end else if (r_state == S_STALL) begin
          w_stall = 1'b1;
          w_fie   = 1'b1;
          if (r_cnt == 2'd0) w_state_nxt = S_IDLE;
          else               w_cnt_nxt   = r_cnt - 2'd1;
        end else if (w_lu) begin
          w_stall = 1'b1;
          w_fie   = 1'b1;
          if (c_LU_MULTI) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = c_LU_INIT;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Outputs are forced low for the whole time reset is held.
  assign branch_taken   = rst_n & w_bt;
  assign flush_if_id    = rst_n & w_fif;
  assign flush_id_ex    = rst_n & w_fie;
  assign stall_pc_if_id = rst_n & w_stall;
  assign busy           = rst_n & (r_state != S_IDLE);

`ifdef BRANCH_HAZARD_STATS_EN
  logic [CNT_W-1:0] r_flush_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_bt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign flush_cnt = rst_n ? r_flush_cnt : '0;
  assign stall_cnt = rst_n ? r_stall_cnt : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_hazard_ctrl : directed self-checking bench for branch_hazard_ctrl.
// Rev 1.0
// ============================================================================
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_valid, ex_mem_read, id_rs_used, id_rt_used;
  logic [3:0] alu_op, ex_rd, id_rs, id_rt;
  logic [2:0] e_flags, e_ccc;

  logic a_bt, a_fif, a_fie, a_st, a_busy;
  logic b_bt, b_fif, b_fie, b_st, b_busy;
  logic [4:0] a_vec, b_vec;

`ifdef BRANCH_HAZARD_STATS_EN
  logic       stat_clr = 1'b0;
  logic [1:0] a_fcnt, a_scnt;
  logic [1:0] b_fcnt, b_scnt;
`endif

  int checks = 0;
  int errors = 0;

  // {branch_taken, flush_if_id, flush_id_ex, stall_pc_if_id, busy}
  localparam logic [4:0] O_IDLE      = 5'b00000;
  localparam logic [4:0] O_TAKE      = 5'b11100;
  localparam logic [4:0] O_TAKE_BUSY = 5'b11101;
  localparam logic [4:0] O_FLUSH     = 5'b01101;
  localparam logic [4:0] O_LU        = 5'b00110;
  localparam logic [4:0] O_STALL     = 5'b00111;

  always #5 clk = ~clk;

  assign a_vec = {a_bt, a_fif, a_fie, a_st, a_busy};
  assign b_vec = {b_bt, b_fif, b_fie, b_st, b_busy};

  branch_hazard_ctrl #(.FLUSH_DEPTH(2), .LU_BUBBLES(3), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_op(alu_op),
    .e_flags(e_flags), .e_ccc(e_ccc), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .branch_taken(a_bt), .flush_if_id(a_fif), .flush_id_ex(a_fie),
    .stall_pc_if_id(a_st),
`ifdef BRANCH_HAZARD_STATS_EN
    .stat_clr(stat_clr), .flush_cnt(a_fcnt), .stall_cnt(a_scnt),
`endif
    .busy(a_busy)
  );

  branch_hazard_ctrl #(.FLUSH_DEPTH(1), .LU_BUBBLES(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_op(alu_op),
    .e_flags(e_flags), .e_ccc(e_ccc), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .branch_taken(b_bt), .flush_if_id(b_fif), .flush_id_ex(b_fie),
    .stall_pc_if_id(b_st),
`ifdef BRANCH_HAZARD_STATS_EN
    .stat_clr(stat_clr), .flush_cnt(b_fcnt), .stall_cnt(b_scnt),
`endif
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; alu_op = 4'b0000; e_flags = 3'b000; e_ccc = 3'b000;
    ex_mem_read = 1'b0; ex_rd = 4'd0; id_rs = 4'd0; id_rt = 4'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0;
  endtask

  task automatic br(input logic [2:0] ccc, input logic [2:0] flg);
    ex_valid = 1'b1; alu_op = 4'b1100; e_ccc = ccc; e_flags = flg;
  endtask

  task automatic lu_in();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd5; id_rt = 4'd5; id_rt_used = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // {ccc, flags{Z,V,N}, expected take}
    logic [6:0] tbl [14] = '{
      {3'b000, 3'b000, 1'b1}, {3'b000, 3'b100, 1'b0}, {3'b001, 3'b000, 1'b0},
      {3'b010, 3'b000, 1'b1}, {3'b010, 3'b100, 1'b0}, {3'b011, 3'b001, 1'b1},
      {3'b011, 3'b000, 1'b0}, {3'b100, 3'b001, 1'b0}, {3'b100, 3'b000, 1'b1},
      {3'b101, 3'b000, 1'b0}, {3'b101, 3'b001, 1'b1}, {3'b110, 3'b010, 1'b1},
      {3'b110, 3'b101, 1'b0}, {3'b111, 3'b000, 1'b1}};

    idle_in();
    br(3'b111, 3'b000); lu_in();
    // Reset held with hazards on the inputs
    nxt(); #1 chk("rst_a0", a_vec, O_IDLE); chk("rst_b0", b_vec, O_IDLE);
    nxt(); #1 chk("rst_a1", a_vec, O_IDLE); chk("rst_b1", b_vec, O_IDLE);
    nxt(); rst_n = 1'b1; idle_in(); #1 chk("post_rst_a", a_vec, O_IDLE);

    // Basic taken branch, take held during FLUSH is ignored by A
    nxt(); br(3'b001, 3'b100); #1 chk("take_c0_a", a_vec, O_TAKE); chk("take_c0_b", b_vec, O_TAKE);
    nxt(); #1 chk("take_c1_a", a_vec, O_FLUSH); chk("take_c1_b", b_vec, O_TAKE);
    nxt(); idle_in(); #1 chk("take_c2_a", a_vec, O_IDLE); chk("take_c2_b", b_vec, O_IDLE);

    // Not taken, then taken with BR_OP1
    nxt(); br(3'b010, 3'b001); #1 chk("nt_a", a_vec, O_IDLE); chk("nt_b", b_vec, O_IDLE);
    nxt(); br(3'b111, 3'b000); alu_op = 4'b1101; #1 chk("op1_a", a_vec, O_TAKE);
    nxt(); idle_in(); #1 chk("op1_c1_a", a_vec, O_FLUSH); chk("op1_c1_b", b_vec, O_IDLE);
    nxt(); #1 chk("op1_c2_a", a_vec, O_IDLE);
    nxt(); br(3'b111, 3'b000); alu_op = 4'b0000; #1 chk("nonbr_a", a_vec, O_IDLE);
    nxt(); br(3'b111, 3'b000); ex_valid = 1'b0; #1 chk("invalid_a", a_vec, O_IDLE);

    // Condition-code table, observed on the single-cycle-flush instance
    for (int i = 0; i < 14; i++) begin
      nxt(); idle_in(); br(tbl[i][6:4], tbl[i][3:1]);
      #1 chk($sformatf("ccc_%0d", i), b_vec, tbl[i][0] ? O_TAKE : O_IDLE);
    end
    nxt(); idle_in();
    nxt(); #1 chk("ccc_end_a", a_vec, O_IDLE);

    // Load-use: three stall cycles on A, one on B
    nxt(); lu_in(); #1 chk("lu_c0_a", a_vec, O_LU); chk("lu_c0_b", b_vec, O_LU);
    nxt(); idle_in(); #1 chk("lu_c1_a", a_vec, O_STALL); chk("lu_c1_b", b_vec, O_IDLE);
    nxt(); #1 chk("lu_c2_a", a_vec, O_STALL);
    nxt(); #1 chk("lu_c3_a", a_vec, O_IDLE);
    nxt(); lu_in(); ex_rd = 4'd0; id_rt = 4'd0; #1 chk("lu_r0_a", a_vec, O_IDLE);
    nxt(); idle_in(); ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd7; id_rs = 4'd7;
    #1 chk("lu_rs_unused_a", a_vec, O_IDLE);
    nxt(); lu_in(); ex_mem_read = 1'b0; #1 chk("lu_noload_a", a_vec, O_IDLE);

    // Take and lu together: take wins
    nxt(); idle_in(); lu_in(); br(3'b111, 3'b000);
    #1 chk("both_a", a_vec, O_TAKE); chk("both_b", b_vec, O_TAKE);
    nxt(); idle_in(); #1 chk("both_c1_a", a_vec, O_FLUSH);
    nxt(); #1 chk("both_c2_a", a_vec, O_IDLE);

    // Taken branch during the 2nd stall cycle aborts the stall
    nxt(); lu_in(); #1 chk("abort_c0_a", a_vec, O_LU); chk("abort_c0_b", b_vec, O_LU);
    nxt(); idle_in(); br(3'b111, 3'b000);
    #1 chk("abort_c1_a", a_vec, O_TAKE_BUSY); chk("abort_c1_b", b_vec, O_TAKE);
    nxt(); idle_in(); #1 chk("abort_c2_a", a_vec, O_FLUSH); chk("abort_c2_b", b_vec, O_IDLE);
    nxt(); #1 chk("abort_c3_a", a_vec, O_IDLE);

    // Reset during FLUSH cycle 1 and during STALL
    nxt(); br(3'b111, 3'b000); #1 chk("rflush_c0_a", a_vec, O_TAKE);
    nxt(); idle_in(); rst_n = 1'b0; br(3'b111, 3'b000); lu_in();
    #1 chk("rflush_rst_a", a_vec, O_IDLE); chk("rflush_rst_b", b_vec, O_IDLE);
    nxt(); rst_n = 1'b1; idle_in(); #1 chk("rflush_rel_a", a_vec, O_IDLE);
    nxt(); br(3'b111, 3'b000); #1 chk("rflush_take_a", a_vec, O_TAKE);
    nxt(); idle_in(); #1 chk("rflush_fl_a", a_vec, O_FLUSH);
    nxt(); lu_in(); #1 chk("rstall_c0_a", a_vec, O_LU);
    nxt(); idle_in(); rst_n = 1'b0; #1 chk("rstall_rst_a", a_vec, O_IDLE);
    nxt(); rst_n = 1'b1; #1 chk("rstall_rel_a", a_vec, O_IDLE);

`ifdef BRANCH_HAZARD_STATS_EN
    nxt(); stat_clr = 1'b1;
    nxt(); stat_clr = 1'b0;
    #1 chk("st_clr_f", {3'b000, a_fcnt}, 5'd0); chk("st_clr_s", {3'b000, a_scnt}, 5'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); br(3'b111, 3'b000); #1 chk($sformatf("st_take_%0d", i), a_vec, O_TAKE);
      nxt(); idle_in();
      #1 chk($sformatf("st_fcnt_%0d", i), {3'b000, a_fcnt}, (i < 3) ? 5'(i + 1) : 5'd3);
    end
    nxt(); br(3'b111, 3'b000); stat_clr = 1'b1; #1 chk("st_clrtake", a_vec, O_TAKE);
    nxt(); idle_in(); stat_clr = 1'b0; #1 chk("st_clr_prio", {3'b000, a_fcnt}, 5'd0);
    nxt();
    nxt(); lu_in(); #1 chk("st_lu_c0", a_vec, O_LU);
    nxt(); idle_in(); #1 chk("st_scnt_1", {3'b000, a_scnt}, 5'd1);
    nxt(); #1 chk("st_scnt_2", {3'b000, a_scnt}, 5'd2);
    nxt(); #1 chk("st_scnt_3", {3'b000, a_scnt}, 5'd3);
`endif

    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
